// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - divided-clock input, strobe and status bundle for clk_div_monitor
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             div_clk;
    logic             clr_fault;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             stalled;
    logic             fault_sticky;

    modport master (
        output div_clk, clr_fault,
        input  rise_pulse, fall_pulse, period, locked, stalled, fault_sticky
    );

    modport slave (
        input  div_clk, clr_fault,
        output rise_pulse, fall_pulse, period, locked, stalled, fault_sticky
    );
endinterface

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - div_clk edge strobes, half/full period measurement, lock/stall/fault monitor
// Optional glitch filter after the synchronizer: define CLK_MON_GLITCH_FILTER_EN.
module clk_div_monitor #(
    parameter int EXP_HALF = 4,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 8
) (
    input  logic             reset,
    input  logic             in_clk,
    clk_div_monitor_if.slave bus
);
    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_LOCKED  = 2'd1;
    localparam logic [1:0] ST_STALL   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_d;
    logic             r_rise_pulse;
    logic             r_fall_pulse;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] r_half_cnt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_period;
    logic             r_first;
    logic             r_fault;

    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic [CNT_W-1:0] w_diff;
    logic             w_good;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_period_sat;
    logic [CNT_W-1:0] w_good_inc;
    logic             w_timeout;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_good_nxt;
    logic             w_first_nxt;
    logic             w_fault_set;
    logic             w_eval;

`ifdef CLK_MON_GLITCH_FILTER_EN
    logic r_f;

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_f <= 1'b0;
        end else begin
            r_f <= r_s2;
        end
    end

    // A new level is only taken once it has been seen on two consecutive samples.
    assign w_level = (r_s2 == r_f) ? r_s2 : r_d;
`else
    assign w_level = r_s2;
`endif

    assign w_rise = w_level & ~r_d;
    assign w_fall = ~w_level & r_d;
    assign w_edge = w_rise | w_fall;

    assign w_diff       = (r_half_cnt > EXP_C) ? (r_half_cnt - EXP_C) : (EXP_C - r_half_cnt);
    assign w_good       = (w_diff <= TOL_C);
    assign w_sum        = {1'b0, r_high} + {1'b0, r_half_cnt};
    assign w_period_sat = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
    assign w_good_inc   = r_good_cnt + ONE_C;
    assign w_timeout    = !w_edge && (r_state != ST_STALL) && (r_half_cnt >= TO_C);
    assign w_eval       = w_edge && (r_state != ST_STALL) && !r_first;

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_first_nxt = r_first;
        w_fault_set = 1'b0;
        if (w_edge) begin
            if (r_state == ST_STALL) begin
                w_state_nxt = ST_ACQUIRE;
                w_first_nxt = 1'b1;
            end else if (r_first) begin
                w_first_nxt = 1'b0;
            end else if (r_state == ST_LOCKED) begin
                if (!w_good) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                    w_fault_set = 1'b1;
                end
            end else if (w_good) begin
                if (w_good_inc == LOCK_C) begin
                    w_state_nxt = ST_LOCKED;
                    w_good_nxt  = '0;
                end else begin
                    w_good_nxt = w_good_inc;
                end
            end else begin
                w_good_nxt = '0;
            end
        end else if (w_timeout) begin
            w_state_nxt = ST_STALL;
            w_good_nxt  = '0;
            w_fault_set = (r_state == ST_LOCKED);
        end
    end

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_d          <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
            r_state      <= ST_ACQUIRE;
            r_good_cnt   <= '0;
            r_half_cnt   <= '0;
            r_high       <= '0;
            r_period     <= '0;
            r_first      <= 1'b1;
            r_fault      <= 1'b0;
        end else begin
            r_s1         <= bus.div_clk;
            r_s2         <= r_s1;
            r_d          <= w_level;
            r_rise_pulse <= w_rise;
            r_fall_pulse <= w_fall;
            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_first      <= w_first_nxt;
            if (w_edge) begin
                r_half_cnt <= ONE_C;
            end else if (r_half_cnt != CNT_MAX) begin
                r_half_cnt <= r_half_cnt + ONE_C;
            end
            if (w_fall) begin
                r_high <= r_half_cnt;
            end
            if (w_eval && w_rise) begin
                r_period <= w_period_sat;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end else if (bus.clr_fault) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign bus.rise_pulse   = r_rise_pulse;
    assign bus.fall_pulse   = r_fall_pulse;
    assign bus.period       = r_period;
    assign bus.locked       = (r_state == ST_LOCKED);
    assign bus.stalled      = (r_state == ST_STALL);
    assign bus.fault_sticky = r_fault;
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side companion of the clock divider: runs on fast in_clk, takes the divided clock back in as div_clk, and treats it as an asynchronous input.
- Turns div_clk into single-cycle rise/fall enable strobes in the in_clk domain.
- Measures div_clk half-periods and full period in in_clk cycles; reports lock, stall and fault so the processor's slow-domain logic can be gated safely.

Parameters:
- EXP_HALF, 4, expected div_clk half-period in in_clk cycles (4 = divide-by-8).
- TOL, 1, allowed ± deviation of a measured half-period from EXP_HALF.
- LOCK_CNT, 4, consecutive good half-periods required to assert locked.
- TIMEOUT, 16, in_clk cycles with no div_clk edge before declaring stall.
- CNT_W, 8, width of half-period counter and period output.

Ports:
- reset  input  1  asynchronous, active-high reset
- in_clk  input  1  fast reference clock; all logic on posedge
- div_clk  input  1  divided clock, asynchronous to in_clk sampling
- clr_fault  input  1  synchronous clear of fault_sticky
- rise_pulse  output  1  one-cycle strobe per div_clk rising edge
- fall_pulse  output  1  one-cycle strobe per div_clk falling edge
- period  output  CNT_W  last measured full period (high half + low half)
- locked  output  1  high in LOCKED state
- stalled  output  1  high in STALL state
- fault_sticky  output  1  set on any bad half-period while LOCKED

Behaviour:
- Reset and clock: reset is asynchronous and active-high; the clock is in_clk. All flops clear on reset.
  - Outputs at reset: rise_pulse=0, fall_pulse=0, period=0, locked=0, stalled=0, fault_sticky=0.
  - Internal state at reset: FSM=ACQUIRE, good_cnt=0, half_cnt=0, first-edge flag set.
- Synchronizer: 2-flop sync s1→s2, then history flop d.
  - Edge detect: rise = s2 & ~d; fall = ~s2 & d.
  - rise_pulse/fall_pulse are registered. If div_clk changes before in_clk edge k, the strobe is high for exactly the cycle after edge k+2 (latency 3 edges).
- Reset release: sync flops reset to 0. If div_clk is already high, one rise is detected after release; it only starts measurement.
- Half counter:
  - Loads 1 on each detected edge; otherwise increments, saturating at 2^CNT_W−1.
  - On an edge, the measured half = half_cnt value before reload. For a divide-by-8 input this is 4.
- First edge: the first edge after reset or after leaving STALL is not evaluated; it only clears the first-edge flag.
- Good half: |measured − EXP_HALF| ≤ TOL, computed unsigned without wrap.
- Period:
  - The high half is captured on each fall.
  - On each evaluated rise, period <= high_half + measured low half, saturated at 2^CNT_W−1.
  - period is updated regardless of FSM state, except on non-evaluated edges.
- FSM:
  - ACQUIRE:
    - Good half: good_cnt+1; when it reaches LOCK_CNT, go to LOCKED (locked=1 the following cycle).
    - Bad half: good_cnt=0.
  - LOCKED:
    - Bad half: go to ACQUIRE, good_cnt=0, fault_sticky=1.
    - Good halves: stay.
  - Any state: half_cnt reaches TIMEOUT with no edge → STALL, stalled=1, locked=0, good_cnt=0.
    - If in LOCKED when this happens, also set fault_sticky.
  - STALL: the next detected edge goes to ACQUIRE and sets the first-edge flag (that edge is not evaluated).
- Simultaneous events:
  - Timeout and edge in the same cycle: the edge wins.
  - clr_fault and a new fault in the same cycle: set wins.
- Reset mid-operation: immediate return to the reset state. Any strobe in flight is dropped.

Optional Feature:
- CLK_MON_GLITCH_FILTER_EN defined:
  - An extra filter flop is added after s2. A level change is accepted only when s2 equals the filter flop for 2 consecutive cycles.
  - Pulses on div_clk shorter than 2 in_clk cycles are ignored.
  - Strobe latency becomes 4 edges.
  - Measured half-period values are unchanged for stable inputs.
- Not defined: no filter; latency 3 edges.

Test Plan:
- Reset, then div_clk toggling every 4 in_clk cycles → strobes alternate 4 cycles apart, period=8, locked=1 after the 4th evaluated half, stalled=0, fault_sticky=0.
- Once locked, stretch one high half to 7 cycles → locked drops, fault_sticky=1, period=11, relock after 4 further good halves. Then pulse clr_fault → fault_sticky=0.
- Hold div_clk low for 20 cycles → stalled=1 when half_cnt hits 16. Resume toggling → stalled=0 at the next edge, first edge not evaluated, relock after 4 good halves.
- Halves of 5 and 3 cycles (within TOL) → locked, period=8. Halves of 6 → never locks, good_cnt stays 0.
- Assert reset mid-lock with div_clk high → all outputs 0 immediately. After release: one rise_pulse 3 edges later, no fault, relock normally.
- Macro defined: 1-cycle glitch on div_clk → no strobe, no measurement disturbance. Macro undefined: same glitch → rise+fall strobes and a bad-half fault.
